branch_compare_pipe: RTL and testbench
======================================

// Module: branch_compare_pipe
// PURPOSE
//   Parametrised successor to the single-cycle 16-bit branch comparator. Compares
//   read_data1 against r15 (signed or unsigned) and evaluates a branch condition.
//   Results are buffered in a DEPTH-entry FIFO with valid/ready handshakes on both
//   sides. Sits between register-read and the fetch-redirect logic of the CPU.
// PARAMETERS
//   WIDTH  16  operand width in bits (>=2)
//   DEPTH  2   result FIFO entries (power of 2, >=2)
//   CNT_W  16  width of statistics counters (BRANCH_STATS_EN only)
// PORTS
//   clk              in   1       rising-edge clock
//   rst              in   1       synchronous reset, active-high
//   in_valid         in   1       operand pair presented
//   in_ready         out  1       FIFO can accept; transfer when in_valid&in_ready
//   in_signed        in   1       1 = two's-complement compare, 0 = unsigned
//   in_cond          in   2       00 BEQ, 01 BLT, 10 BGT, 11 BNE
//   read_data1       in   WIDTH   operand A
//   r15              in   WIDTH   operand B
//   out_valid        out  1       head result valid
//   out_ready        in   1       consumer accepts; pop when out_valid&out_ready
//   out_branch       out  2       relation: 00 A==B, 01 A<B, 10 A>B (11 never)
//   out_taken        out  1       condition in_cond satisfied for this entry
//   stats_clr        in   1       clear statistics counters (BRANCH_STATS_EN)
//   taken_cnt        out  CNT_W  popped results with taken=1 (BRANCH_STATS_EN)
//   not_taken_cnt    out  CNT_W  popped results with taken=0 (BRANCH_STATS_EN)
// BEHAVIOUR
//   - Reset: FIFO empty (count=0, rd/wr pointers 0), in_ready=1, out_valid=0,
//     out_branch=00, out_taken=0, counters 0. Reset mid-stream discards all entries.
//   - Compare is combinational on the accept cycle; {branch,taken} written to FIFO.
//     Latency: accept in cycle N -> out_valid=1 in cycle N+1 if FIFO was empty.
//   - in_ready = (count != DEPTH); registered-state only, no dependence on out_ready.
//   - out_valid = (count != 0); out_branch/out_taken driven from head entry, stable
//     while out_valid=1 and out_ready=0.
//   - Simultaneous push and pop: count unchanged, both pointers advance.
//   - Full: in_ready=0; a pop that cycle frees a slot, in_ready=1 next cycle.
//   - Empty: out_valid=0, out_branch/out_taken hold last popped value (00/0 after rst).
//   - Pointers are log2(DEPTH) bits and wrap naturally.
//   - Signed mode: MSB is sign; 0x8000 < 0x0001 signed, > unsigned (WIDTH=16).
//   - taken: BEQ eq; BLT lt; BGT gt; BNE !eq.
// CONFIGURATION
//   BRANCH_STATS_EN defined: taken_cnt/not_taken_cnt increment on each pop per
//     out_taken; saturate at all-ones; stats_clr zeroes both and wins over a
//     same-cycle increment.
//   BRANCH_STATS_EN undefined: stats_clr, taken_cnt, not_taken_cnt ports absent;
//     no counter logic.
// TESTING
//   1. rst=1 2 cycles -> in_ready=1, out_valid=0, out_branch=00, out_taken=0.
//   2. A=0002,B=0002,cond=00, out_ready=1 -> next cycle out_branch=00, out_taken=1.
//   3. A=0003,B=0001 then A=0001,B=0003 unsigned cond=01 -> 10/taken=0, 01/taken=1.
//   4. signed=1, A=8000,B=0001,cond=01 -> branch=01,taken=1; signed=0 -> 10,taken=0.
//   5. out_ready=0, push 3 -> in_ready=0 after 2nd push; out data stable; raise
//      out_ready -> entries drain in order, in_ready=1 cycle after first pop.
//   6. BRANCH_STATS_EN, CNT_W=2: pop 5 taken -> taken_cnt=3 (sat); stats_clr with
//      pop same cycle -> taken_cnt=0.

Source files
------------

// File: rtl/branch_compare_pipe.sv
// Branch comparator with a result FIFO: compares read_data1 vs r15 and evaluates in_cond.
// Latency: accept in cycle N gives out_valid in cycle N+1 when the FIFO was empty.
// Backpressure: in_ready = FIFO not full (registered only); optional stats via BRANCH_STATS_EN.
module branch_compare_pipe #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [1:0]       in_cond,
  input  logic [WIDTH-1:0] read_data1,
  input  logic [WIDTH-1:0] r15,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_branch,
  output logic             out_taken
`ifdef BRANCH_STATS_EN
  ,
  input  logic             stats_clr,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] not_taken_cnt
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  // Reject configurations the pointer arithmetic cannot support.
  if (WIDTH < 2 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || CNT_W < 1) begin : g_bad_param
    $error("branch_compare_pipe: illegal parameter set");
  end

  // Each entry is {branch[1:0], taken}.
  logic [2:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [2:0]    last_pop;
  logic          push;
  logic          pop;
  logic          eq;
  logic          lt;
  logic [1:0]    rel;
  logic          tk;

  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Relation and branch condition for the operand pair being presented.
  always_comb begin
    eq  = (read_data1 == r15);
    lt  = in_signed ? ($signed(read_data1) < $signed(r15)) : (read_data1 < r15);
    rel = eq ? 2'b00 : (lt ? 2'b01 : 2'b10);
    tk  = 1'b0;
    case (in_cond)
      2'b00:   tk = eq;
      2'b01:   tk = lt;
      2'b10:   tk = ~eq & ~lt;
      default: tk = ~eq;
    endcase
  end

  // FIFO storage, pointers and occupancy; push and pop may happen together.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {rel, tk};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Remember the last popped result so outputs hold it while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (rst)      last_pop <= '0;
    else if (pop) last_pop <= mem[rd_ptr];
  end

  // Head entry when valid, otherwise the last popped value.
  always_comb begin
    out_branch = last_pop[2:1];
    out_taken  = last_pop[0];
    if (out_valid) begin
      out_branch = mem[rd_ptr][2:1];
      out_taken  = mem[rd_ptr][0];
    end
  end

`ifdef BRANCH_STATS_EN
  // Saturating pop statistics; a clear overrides any same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || stats_clr) begin
      taken_cnt     <= '0;
      not_taken_cnt <= '0;
    end else if (pop) begin
      if (mem[rd_ptr][0]) begin
        if (taken_cnt != '1) taken_cnt <= taken_cnt + 1'b1;
      end else begin
        if (not_taken_cnt != '1) not_taken_cnt <= not_taken_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_compare_pipe.sv
// Directed self-checking bench for branch_compare_pipe (DEPTH=2, WIDTH=16).
// Inputs change and outputs are sampled on the falling clock edge.
// Statistics scenario is built only when BRANCH_STATS_EN is defined (CNT_W=2).
module tb_branch_compare_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_signed;
  logic [1:0]  in_cond;
  logic [15:0] read_data1;
  logic [15:0] r15;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_branch;
  logic        out_taken;
`ifdef BRANCH_STATS_EN
  logic        stats_clr;
  logic [1:0]  taken_cnt;
  logic [1:0]  not_taken_cnt;
`endif

  int total;
  int bad;

  branch_compare_pipe #(.WIDTH(16), .DEPTH(2), .CNT_W(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_signed(in_signed), .in_cond(in_cond),
    .read_data1(read_data1), .r15(r15),
    .out_valid(out_valid), .out_ready(out_ready), .out_branch(out_branch), .out_taken(out_taken)
`ifdef BRANCH_STATS_EN
    , .stats_clr(stats_clr), .taken_cnt(taken_cnt), .not_taken_cnt(not_taken_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one operand pair for exactly one rising edge; returns on the following falling edge.
  task automatic push_one(input logic [15:0] a, input logic [15:0] b, input logic sgn, input logic [1:0] c);
    read_data1 = a; r15 = b; in_signed = sgn; in_cond = c; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (in_ready !== 1'b1)    begin bad++; $display("FAIL rst_in_ready got=%b want=1", in_ready); end
    total++; if (out_valid !== 1'b0)   begin bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
    total++; if (out_branch !== 2'b00) begin bad++; $display("FAIL rst_out_branch got=%b want=00", out_branch); end
    total++; if (out_taken !== 1'b0)   begin bad++; $display("FAIL rst_out_taken got=%b want=0", out_taken); end
  endtask

  task automatic test_beq();
    out_ready = 1'b1;
    push_one(16'h0002, 16'h0002, 1'b0, 2'b00);
    total++; if (out_valid !== 1'b1)   begin bad++; $display("FAIL beq_valid got=%b want=1", out_valid); end
    total++; if (out_branch !== 2'b00) begin bad++; $display("FAIL beq_branch got=%b want=00", out_branch); end
    total++; if (out_taken !== 1'b1)   begin bad++; $display("FAIL beq_taken got=%b want=1", out_taken); end
  endtask

  task automatic test_unsigned_blt();
    out_ready = 1'b1;
    push_one(16'h0003, 16'h0001, 1'b0, 2'b01);
    total++; if ({out_branch, out_taken} !== 3'b10_0) begin bad++; $display("FAIL ublt_gt got=%b want=100", {out_branch, out_taken}); end
    push_one(16'h0001, 16'h0003, 1'b0, 2'b01);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL ublt_valid got=%b want=1", out_valid); end
    total++; if ({out_branch, out_taken} !== 3'b01_1) begin bad++; $display("FAIL ublt_lt got=%b want=011", {out_branch, out_taken}); end
  endtask

  task automatic test_signed();
    out_ready = 1'b1;
    push_one(16'h8000, 16'h0001, 1'b1, 2'b01);
    total++; if ({out_branch, out_taken} !== 3'b01_1) begin bad++; $display("FAIL signed_blt got=%b want=011", {out_branch, out_taken}); end
    push_one(16'h8000, 16'h0001, 1'b0, 2'b01);
    total++; if ({out_branch, out_taken} !== 3'b10_0) begin bad++; $display("FAIL unsigned_blt got=%b want=100", {out_branch, out_taken}); end
    push_one(16'h7FFF, 16'hFFFF, 1'b1, 2'b10);
    total++; if ({out_branch, out_taken} !== 3'b10_1) begin bad++; $display("FAIL signed_bgt got=%b want=101", {out_branch, out_taken}); end
    push_one(16'h1234, 16'h1235, 1'b0, 2'b11);
    total++; if ({out_branch, out_taken} !== 3'b01_1) begin bad++; $display("FAIL bne got=%b want=011", {out_branch, out_taken}); end
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL drain_valid got=%b want=0", out_valid); end
  endtask

  task automatic test_full_backpressure();
    out_ready = 1'b0;
    push_one(16'h0001, 16'h0002, 1'b0, 2'b01);  // 01 taken
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL full_rdy1 got=%b want=1", in_ready); end
    push_one(16'h0005, 16'h0005, 1'b0, 2'b11);  // 00 not taken
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_rdy2 got=%b want=0", in_ready); end
    total++; if ({out_branch, out_taken} !== 3'b01_1) begin bad++; $display("FAIL full_head got=%b want=011", {out_branch, out_taken}); end
    // Third entry waits while the FIFO is full.
    read_data1 = 16'h0009; r15 = 16'h0003; in_signed = 1'b0; in_cond = 2'b10; in_valid = 1'b1;
    @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_hold_rdy got=%b want=0", in_ready); end
    total++; if ({out_branch, out_taken} !== 3'b01_1) begin bad++; $display("FAIL full_stable got=%b want=011", {out_branch, out_taken}); end
    out_ready = 1'b1;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL pop_frees got=%b want=1", in_ready); end
    total++; if ({out_branch, out_taken} !== 3'b00_0) begin bad++; $display("FAIL order2 got=%b want=000", {out_branch, out_taken}); end
    @(negedge clk);
    in_valid = 1'b0;
    total++; if ({out_branch, out_taken} !== 3'b10_1) begin bad++; $display("FAIL order3 got=%b want=101", {out_branch, out_taken}); end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL order3_valid got=%b want=1", out_valid); end
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL empty_valid got=%b want=0", out_valid); end
    total++; if ({out_branch, out_taken} !== 3'b10_1) begin bad++; $display("FAIL empty_hold got=%b want=101", {out_branch, out_taken}); end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    push_one(16'h0004, 16'h0004, 1'b0, 2'b00);
    push_one(16'h0004, 16'h0003, 1'b0, 2'b10);
    do_reset();
    total++; if (out_valid !== 1'b0)  begin bad++; $display("FAIL midrst_valid got=%b want=0", out_valid); end
    total++; if (in_ready !== 1'b1)   begin bad++; $display("FAIL midrst_ready got=%b want=1", in_ready); end
    total++; if ({out_branch, out_taken} !== 3'b00_0) begin bad++; $display("FAIL midrst_out got=%b want=000", {out_branch, out_taken}); end
  endtask

`ifdef BRANCH_STATS_EN
  task automatic test_stats();
    do_reset();
    out_ready = 1'b1;
    read_data1 = 16'h0007; r15 = 16'h0007; in_signed = 1'b0; in_cond = 2'b00; in_valid = 1'b1;
    repeat (5) @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    total++; if (taken_cnt !== 2'd3)     begin bad++; $display("FAIL stats_sat got=%0d want=3", taken_cnt); end
    total++; if (not_taken_cnt !== 2'd0) begin bad++; $display("FAIL stats_nt got=%0d want=0", not_taken_cnt); end
    push_one(16'h0007, 16'h0007, 1'b0, 2'b00);
    stats_clr = 1'b1;
    @(negedge clk);
    stats_clr = 1'b0;
    total++; if (taken_cnt !== 2'd0) begin bad++; $display("FAIL stats_clr got=%0d want=0", taken_cnt); end
    push_one(16'h0001, 16'h0007, 1'b0, 2'b00);
    @(negedge clk);
    total++; if (not_taken_cnt !== 2'd1) begin bad++; $display("FAIL stats_nt_inc got=%0d want=1", not_taken_cnt); end
  endtask
`endif

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; in_valid = 1'b0; in_signed = 1'b0; in_cond = 2'b00;
    read_data1 = '0; r15 = '0; out_ready = 1'b0;
`ifdef BRANCH_STATS_EN
    stats_clr = 1'b0;
`endif
    test_reset();
    test_beq();
    test_unsigned_blt();
    test_signed();
    test_full_backpressure();
    test_reset_midstream();
`ifdef BRANCH_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
